// File: rtl/fifo_pkg.sv
// Shared defaults for the self-pointered FIFO: geometry, flag thresholds and
// the per-edge operation encoding used by the occupancy counter.
package fifo_pkg;

  localparam int FIFO_MEM_SIZE        = 8;
  localparam int FIFO_WORD_SIZE       = 10;
  localparam int FIFO_PTR             = 3;
  localparam int FIFO_ALMOST_FULL_TH  = 6;
  localparam int FIFO_ALMOST_EMPTY_TH = 2;

  // {write accepted, read accepted} for one clock edge
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read that holds its
// output while rd_en is low. Only the read register is reset, never the array.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE  = FIFO_MEM_SIZE,
  parameter int WORD_SIZE = FIFO_WORD_SIZE,
  parameter int PTR       = FIFO_PTR
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [PTR-1:0]       wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [PTR-1:0]       rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-address write and read on one edge returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_ctrl_mem.sv
// Synchronous FIFO with internal pointers, occupancy count and status flags.
// Defining FIFO_ERR_EN adds a sticky error output for dropped pushes / ignored pops.
module fifo_ctrl_mem
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE        = FIFO_MEM_SIZE,
  parameter int WORD_SIZE       = FIFO_WORD_SIZE,
  parameter int PTR             = FIFO_PTR,
  parameter int ALMOST_FULL_TH  = FIFO_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = FIFO_ALMOST_EMPTY_TH
)
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 push,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR:0]         fifo_count
`ifdef FIFO_ERR_EN
  ,
  output logic                 error
`endif
);

  localparam logic [PTR:0] FULL_CNT = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0] AF_CNT   = (PTR+1)'(ALMOST_FULL_TH);
  localparam logic [PTR:0] AE_CNT   = (PTR+1)'(ALMOST_EMPTY_TH);

  logic [PTR-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR:0]   count_reg, count_next;
  logic           valid_reg;
  logic           wr_accept, rd_accept;
  fifo_op_e       op;

  // A pop frees a slot on the same edge, so a push at full still lands.
  assign wr_accept = push && (!full || pop);
  assign rd_accept = pop && !empty;
  assign op        = fifo_op_e'({wr_accept, rd_accept});

  assign full         = (count_reg == FULL_CNT);
  assign empty        = (count_reg == '0);
  assign almost_full  = (count_reg >= AF_CNT);
  assign almost_empty = (count_reg <= AE_CNT);
  assign fifo_count   = count_reg;
  assign valid_out    = valid_reg;

  always_comb begin
    wr_ptr_next = wr_accept ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = rd_accept ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case (op)
      OP_WRITE: count_next = count_reg + 1'b1;
      OP_READ:  count_next = count_reg - 1'b1;
      default:  count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= rd_accept;
    end
  end

  fifo_ram #(
    .MEM_SIZE  (MEM_SIZE),
    .WORD_SIZE (WORD_SIZE),
    .PTR       (PTR)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_accept && reset),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_reg),
    .rd_data (data_out)
  );

`ifdef FIFO_ERR_EN
  logic error_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_reg <= 1'b0;
    end else if ((push && !wr_accept) || (pop && !rd_accept)) begin
      error_reg <= 1'b1;
    end
  end

  assign error = error_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl_mem.sv
// Scoreboard bench for fifo_ctrl_mem: a queue model of the FIFO feeds expected
// read words into sb_q, which are popped when the DUT strobes valid_out.
module tb_fifo_ctrl_mem;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] data_in = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [9:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] fifo_count;
`ifdef FIFO_ERR_EN
  logic       error;
`endif

  int checks = 0;
  int errors = 0;

  logic [9:0] model_q[$];
  logic [9:0] sb_q[$];
  logic       model_err = 1'b0;
  logic       exp_valid = 1'b0;

  fifo_ctrl_mem dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .push         (push),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count)
`ifdef FIFO_ERR_EN
    ,
    .error        (error)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of push/pop, update the reference model, sample 1 time unit after the edge.
  task automatic step(input logic p, input logic q, input logic [9:0] d);
    logic wr_ok, rd_ok;
    wr_ok = p && (model_q.size() < 8 || q);
    rd_ok = q && (model_q.size() != 0);
    if (rd_ok) sb_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    if ((p && !wr_ok) || (q && !rd_ok)) model_err = 1'b1;
    exp_valid = rd_ok;
    push = p; pop = q; data_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_out !== 10'h000 || valid_out !== 1'b0 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: data_out=%h valid_out=%b count=%0d required 000/0/0", data_out, valid_out, fifo_count);
    end
    checks++;
    if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b ae=%b full=%b af=%b required 1/1/0/0", empty, almost_empty, full, almost_full);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 10'(i));
      checks++;
      if (fifo_count !== 4'(i) || almost_full !== (i >= 6) || full !== (i == 8) || empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b required %0d/%b/%b/0",
                 i, fifo_count, almost_full, full, empty, i, (i >= 6), (i == 8));
      end
    end
    step(1'b1, 1'b0, 10'h3FF);
    checks++;
    if (fifo_count !== 4'd8 || full !== 1'b1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL fill_drop: count=%0d full=%b valid=%b required 8/1/0", fifo_count, full, valid_out);
    end
`ifdef FIFO_ERR_EN
    checks++;
    if (error !== model_err) begin
      errors++;
      $display("FAIL fill_error: error=%b required %b", error, model_err);
    end
`endif
  endtask

  task automatic test_drain();
    logic [9:0] exp;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 10'h000);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL drain_%0d: scoreboard empty", i);
      end else begin
        exp = sb_q.pop_front();
        if (valid_out !== 1'b1 || data_out !== exp || data_out !== 10'(i)) begin
          errors++;
          $display("FAIL drain_%0d: data_out=%h valid=%b required %h/1", i, data_out, valid_out, exp);
        end
      end
    end
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (valid_out !== 1'b0 || data_out !== 10'h008 || empty !== 1'b1 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL drain_extra: data_out=%h valid=%b empty=%b count=%0d required 008/0/1/0",
               data_out, valid_out, empty, fifo_count);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h050 + 10'(i));
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 10'h000);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
      checks++;
      if (valid_out !== exp_valid || data_out !== exp) begin
        errors++;
        $display("FAIL wrap_a_%0d: data_out=%h valid=%b required %h/1", i, data_out, valid_out, exp);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 10'h100 + 10'(i));
    checks++;
    if (fifo_count !== 4'd6 || almost_full !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: count=%0d af=%b required 6/1", fifo_count, almost_full);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 10'h000);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp || data_out !== 10'h100 + 10'(i)) begin
        errors++;
        $display("FAIL wrap_b_%0d: data_out=%h valid=%b required %h/1", i, data_out, valid_out, 10'h100 + 10'(i));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [9:0] exp;
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 10'h200 + 10'(i));
    step(1'b1, 1'b1, 10'h2AA);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
    checks++;
    if (valid_out !== 1'b1 || data_out !== exp || data_out !== 10'h201 || fifo_count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL sim_full: data_out=%h valid=%b count=%0d required 201/1/8", data_out, valid_out, fifo_count);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 10'h000);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
      checks++;
      if (valid_out !== 1'b1 || data_out !== exp) begin
        errors++;
        $display("FAIL sim_drain_%0d: data_out=%h valid=%b required %h/1", i, data_out, valid_out, exp);
      end
    end
    step(1'b1, 1'b1, 10'h155);
    checks++;
    if (fifo_count !== 4'd1 || valid_out !== 1'b0 || empty !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL sim_empty: count=%0d valid=%b empty=%b ae=%b required 1/0/0/1",
               fifo_count, valid_out, empty, almost_empty);
    end
    step(1'b0, 1'b1, 10'h000);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 10'h3FF;
    checks++;
    if (valid_out !== 1'b1 || data_out !== exp || data_out !== 10'h155 || fifo_count !== 4'd0) begin
      errors++;
      $display("FAIL sim_readback: data_out=%h valid=%b count=%0d required 155/1/0", data_out, valid_out, fifo_count);
    end
`ifdef FIFO_ERR_EN
    checks++;
    if (error !== model_err) begin
      errors++;
      $display("FAIL sim_error: error=%b required %b", error, model_err);
    end
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'h0C0 + 10'(i));
    step(1'b1, 1'b1, 10'h0CF);
    #3 reset = 1'b0;
    #1;
    model_q.delete();
    sb_q.delete();
    model_err = 1'b0;
    checks++;
    if (fifo_count !== 4'd0 || empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 10'h000) begin
      errors++;
      $display("FAIL mid_reset: count=%0d empty=%b valid=%b data_out=%h required 0/1/0/000",
               fifo_count, empty, valid_out, data_out);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    step(1'b0, 1'b1, 10'h000);
    checks++;
    if (valid_out !== 1'b0 || fifo_count !== 4'd0 || empty !== 1'b1 || data_out !== 10'h000) begin
      errors++;
      $display("FAIL post_reset_pop: valid=%b count=%0d empty=%b data_out=%h required 0/0/1/000",
               valid_out, fifo_count, empty, data_out);
    end
`ifdef FIFO_ERR_EN
    checks++;
    if (error !== model_err) begin
      errors++;
      $display("FAIL post_reset_error: error=%b required %b", error, model_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
